prefix_decoder: RTL and testbench
=================================

Name: prefix_decoder

Overview:
Front of the instruction decode path. Pops bytes from the show-ahead prefetch FIFO and classifies each one as a prefix or an opcode. Segment-override prefixes are issued to the segment override logic as an update / segment_override / override_in pulse. REP and LOCK state is accumulated, and the first non-prefix byte is held as the opcode until the decoder accepts it.

Parameters:
MAX_PREFIXES, 15, prefix count at which prefix_count saturates and prefix_overflow sets.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
fifo_rd_data  in  8  head byte of prefetch FIFO; valid when fifo_empty=0
fifo_empty  in  1  FIFO has no byte
fifo_rd_en  out  1  pop head byte this cycle (combinational)
flush  in  1  branch or interrupt flush; abandon the current instruction
next_instruction  in  1  current instruction retired; start a new scan
opcode_ack  in  1  decoder has taken the opcode
update  out  1  one-cycle pulse: a prefix was consumed
segment_override  out  1  qualifies update: the prefix was a segment override
override_in  out  2  segment register of the override (ES=0, CS=1, SS=2, DS=3)
opcode  out  8  held opcode byte
opcode_valid  out  1  opcode is presented
rep_prefix  out  2  00 none, 10 REPNE (F2), 11 REP/REPE (F3)
lock  out  1  LOCK (F0) seen for the current instruction
prefix_count  out  $clog2(MAX_PREFIXES+1)  prefixes consumed; saturating
prefix_overflow  out  1  sticky; set when a prefix arrives with prefix_count=MAX_PREFIXES

Behaviour:
- States: SCAN, HOLD, EXEC. Reset: state=SCAN; all outputs 0, including opcode=00.
- fifo_rd_en = (state==SCAN) & ~fifo_empty & ~flush.
- Prefix bytes: 26/2E/36/3E (segment ES/CS/SS/DS), F2, F3, F0. Every other byte is an opcode.
- SCAN, prefix popped, cycle N. Registered outputs in cycle N+1:
  - update=1.
  - Segment prefix: segment_override=1 and override_in=encoding. Otherwise segment_override=0 and override_in=00.
  - F2/F3 overwrite rep_prefix; the last one wins.
  - F0 sets lock.
  - prefix_count increments, saturating at MAX_PREFIXES. A prefix arriving at saturation sets prefix_overflow and does not increment.
  - State stays SCAN. Back-to-back prefixes give back-to-back update pulses, one per byte.
- SCAN, opcode popped, cycle N: in cycle N+1, opcode=byte, opcode_valid=1, state=HOLD, update=0.
- HOLD:
  - No pops.
  - opcode_valid stays 1 and opcode is stable until opcode_ack.
  - On opcode_ack: next cycle opcode_valid=0 and state=EXEC. opcode keeps its value.
- EXEC:
  - No pops; immediates and ModRM bytes are consumed by other logic.
  - rep_prefix, lock and prefix_count stay stable.
  - On next_instruction: next cycle state=SCAN, and rep_prefix, lock, prefix_count and prefix_overflow clear to 0.
- next_instruction in SCAN or HOLD: ignored.
- flush, any state:
  - Next cycle state=SCAN; opcode_valid, update, segment_override, rep_prefix, lock, prefix_count and prefix_overflow are all 0.
  - A byte presented in the flush cycle is not popped.
  - flush has priority over opcode_ack and next_instruction.
- update and segment_override are high for exactly one cycle per prefix. They are never high in HOLD or EXEC, or in the cycle after flush.
- fifo_empty in SCAN: no pop, no state change, outputs hold; update=0.
- reset asserted mid-instruction: immediate return to reset values, asynchronously.

Decomposition:
- Shared package (existing core package): segment register encodings ES/CS/SS/DS; prefix byte constants PFX_ES, PFX_CS, PFX_SS, PFX_DS, PFX_REPNE, PFX_REP, PFX_LOCK; the rep_prefix encoding.
- State enum lives locally in the module.
- One natural sub-module, prefix_classifier (combinational). Input: byte. Outputs: is_prefix, is_seg, seg[1:0], is_rep, rep[1:0], is_lock.

Test Plan:
- Bytes 26,36,8B in consecutive cycles -> update pulses on two cycles with override_in 0 then 2; opcode=8B with opcode_valid=1 on the 3rd cycle after the first pop; prefix_count=2.
- F3,F2,A4 -> rep_prefix=11 then 10; update=1 with segment_override=0 on both; opcode=A4 held through 5 cycles without opcode_ack; fifo_rd_en=0 throughout HOLD.
- F0,90 -> lock=1; opcode_ack then next_instruction -> lock=0 and prefix_count=0 the next cycle; fifo_rd_en resumes.
- flush in the same cycle as a 2E head byte -> no pop, no update pulse; next cycle state=SCAN with all outputs 0.
- MAX_PREFIXES=2 with 26,26,26,90 -> prefix_count=2, prefix_overflow=1, opcode=90.
- Reset asserted in HOLD with opcode=8B -> opcode_valid=0 and opcode=00 immediately (asynchronous); after reset deassertion, the next byte is treated as a fresh scan.

Source files
------------

// File: rtl/prefix_decoder_pkg.sv
// Shared decode-path constants: prefix byte values, segment register
// encodings and the REP field encoding.
package prefix_decoder_pkg;

    typedef enum logic [1:0] {
        SEG_ES = 2'd0,
        SEG_CS = 2'd1,
        SEG_SS = 2'd2,
        SEG_DS = 2'd3
    } seg_t;

    localparam logic [7:0] PFX_ES    = 8'h26;
    localparam logic [7:0] PFX_CS    = 8'h2E;
    localparam logic [7:0] PFX_SS    = 8'h36;
    localparam logic [7:0] PFX_DS    = 8'h3E;
    localparam logic [7:0] PFX_REPNE = 8'hF2;
    localparam logic [7:0] PFX_REP   = 8'hF3;
    localparam logic [7:0] PFX_LOCK  = 8'hF0;

    localparam logic [1:0] REP_NONE = 2'b00;
    localparam logic [1:0] REP_NE   = 2'b10;
    localparam logic [1:0] REP_E    = 2'b11;

    function automatic int count_width(input int max_prefixes);
        return $clog2(max_prefixes + 1);
    endfunction

endpackage

// File: rtl/prefix_decoder_if.sv
// Prefetch FIFO, decoder handshake and segment-override signals of the
// prefix decoder. slave = the prefix decoder, master = its surroundings.
interface prefix_decoder_if #(parameter int MAX_PREFIXES = 15);
    import prefix_decoder_pkg::*;

    localparam int CNT_W = count_width(MAX_PREFIXES);

    logic [7:0]       fifo_rd_data;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             flush;
    logic             next_instruction;
    logic             opcode_ack;
    logic             update;
    logic             segment_override;
    logic [1:0]       override_in;
    logic [7:0]       opcode;
    logic             opcode_valid;
    logic [1:0]       rep_prefix;
    logic             lock;
    logic [CNT_W-1:0] prefix_count;
    logic             prefix_overflow;

    modport slave (
        input  fifo_rd_data, fifo_empty, flush, next_instruction, opcode_ack,
        output fifo_rd_en, update, segment_override, override_in, opcode,
               opcode_valid, rep_prefix, lock, prefix_count, prefix_overflow
    );

    modport master (
        output fifo_rd_data, fifo_empty, flush, next_instruction, opcode_ack,
        input  fifo_rd_en, update, segment_override, override_in, opcode,
               opcode_valid, rep_prefix, lock, prefix_count, prefix_overflow
    );

endinterface

// File: rtl/prefix_decoder_classifier.sv
// Combinational byte classifier: recognises segment, REP/REPNE and LOCK
// prefixes; anything else is an opcode.
module prefix_classifier
    import prefix_decoder_pkg::*;
(
    input  logic [7:0] data_in,
    output logic       is_prefix,
    output logic       is_seg,
    output logic [1:0] seg,
    output logic       is_rep,
    output logic [1:0] rep,
    output logic       is_lock
);

    always_comb begin
        is_seg  = 1'b0;
        seg     = SEG_ES;
        is_rep  = 1'b0;
        rep     = REP_NONE;
        is_lock = 1'b0;
        case (data_in)
            PFX_ES:    begin is_seg = 1'b1; seg = SEG_ES; end
            PFX_CS:    begin is_seg = 1'b1; seg = SEG_CS; end
            PFX_SS:    begin is_seg = 1'b1; seg = SEG_SS; end
            PFX_DS:    begin is_seg = 1'b1; seg = SEG_DS; end
            PFX_REPNE: begin is_rep = 1'b1; rep = REP_NE; end
            PFX_REP:   begin is_rep = 1'b1; rep = REP_E;  end
            PFX_LOCK:  is_lock = 1'b1;
            default:   ;
        endcase
        is_prefix = is_seg | is_rep | is_lock;
    end

endmodule

// File: rtl/prefix_decoder.sv
// Instruction prefix scanner: pops prefetch bytes, accumulates prefix state
// and holds the first non-prefix byte as the opcode.
//   state | meaning
//   SCAN  | popping bytes, consuming prefixes
//   HOLD  | opcode presented, waiting for opcode_ack
//   EXEC  | opcode taken, waiting for next_instruction
module prefix_decoder
    import prefix_decoder_pkg::*;
#(
    parameter int MAX_PREFIXES = 15
) (
    input  logic               clk,
    input  logic               reset,
    prefix_decoder_if.slave    bus
);

    localparam int CNT_W = count_width(MAX_PREFIXES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PREFIXES);

    typedef enum logic [1:0] {SCAN, HOLD, EXEC} state_t;

    state_t           state, state_n;
    logic             update_q, update_n;
    logic             seg_ovr_q, seg_ovr_n;
    logic [1:0]       ovr_q, ovr_n;
    logic [7:0]       opcode_q, opcode_n;
    logic             valid_q, valid_n;
    logic [1:0]       rep_q, rep_n;
    logic             lock_q, lock_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             ovf_q, ovf_n;

    logic             is_prefix, is_seg, is_rep, is_lock;
    logic [1:0]       seg, rep;
    logic             pop;

    prefix_classifier u_classifier (
        .data_in   (bus.fifo_rd_data),
        .is_prefix (is_prefix),
        .is_seg    (is_seg),
        .seg       (seg),
        .is_rep    (is_rep),
        .rep       (rep),
        .is_lock   (is_lock)
    );

    assign pop = (state == SCAN) & ~bus.fifo_empty & ~bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            update_q  <= 1'b0;
            seg_ovr_q <= 1'b0;
            ovr_q     <= 2'b00;
            opcode_q  <= 8'h00;
            valid_q   <= 1'b0;
            rep_q     <= REP_NONE;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_n;
            update_q  <= update_n;
            seg_ovr_q <= seg_ovr_n;
            ovr_q     <= ovr_n;
            opcode_q  <= opcode_n;
            valid_q   <= valid_n;
            rep_q     <= rep_n;
            lock_q    <= lock_n;
            cnt_q     <= cnt_n;
            ovf_q     <= ovf_n;
        end
    end

    // The update/override trio is a pulse, so it defaults to zero every cycle.
    always_comb begin
        state_n   = state;
        update_n  = 1'b0;
        seg_ovr_n = 1'b0;
        ovr_n     = 2'b00;
        opcode_n  = opcode_q;
        valid_n   = valid_q;
        rep_n     = rep_q;
        lock_n    = lock_q;
        cnt_n     = cnt_q;
        ovf_n     = ovf_q;
        if (bus.flush) begin
            state_n = SCAN;
            valid_n = 1'b0;
            rep_n   = REP_NONE;
            lock_n  = 1'b0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (pop && is_prefix) begin
                        update_n = 1'b1;
                        if (is_seg) begin
                            seg_ovr_n = 1'b1;
                            ovr_n     = seg;
                        end
                        if (is_rep)  rep_n  = rep;
                        if (is_lock) lock_n = 1'b1;
                        if (cnt_q == CNT_MAX) ovf_n = 1'b1;
                        else                  cnt_n = cnt_q + 1'b1;
                    end else if (pop) begin
                        opcode_n = bus.fifo_rd_data;
                        valid_n  = 1'b1;
                        state_n  = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.opcode_ack) begin
                        valid_n = 1'b0;
                        state_n = EXEC;
                    end
                end
                EXEC: begin
                    if (bus.next_instruction) begin
                        state_n = SCAN;
                        rep_n   = REP_NONE;
                        lock_n  = 1'b0;
                        cnt_n   = '0;
                        ovf_n   = 1'b0;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    assign bus.fifo_rd_en       = pop;
    assign bus.update           = update_q;
    assign bus.segment_override = seg_ovr_q;
    assign bus.override_in      = ovr_q;
    assign bus.opcode           = opcode_q;
    assign bus.opcode_valid     = valid_q;
    assign bus.rep_prefix       = rep_q;
    assign bus.lock             = lock_q;
    assign bus.prefix_count     = cnt_q;
    assign bus.prefix_overflow  = ovf_q;

endmodule

// File: tb/tb_prefix_decoder.sv
// Scoreboard bench for prefix_decoder: each byte loaded into the modelled
// prefetch FIFO queues its expected update or opcode event.
module tb_prefix_decoder;

    localparam int MAX_P = 2;

    typedef struct packed {
        logic       is_opc;
        logic       seg;
        logic [1:0] ovr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prefix_decoder_if #(.MAX_PREFIXES(MAX_P)) bus ();

    prefix_decoder #(.MAX_PREFIXES(MAX_P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       prev_ov = 1'b0;
    logic       last_pop = 1'b0;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty   = (fifo_q.size() == 0);
        bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic load(input logic [7:0] b);
        exp_t e;
        e = '0;
        case (b)
            8'h26: begin e.seg = 1'b1; e.ovr = 2'd0; end
            8'h2E: begin e.seg = 1'b1; e.ovr = 2'd1; end
            8'h36: begin e.seg = 1'b1; e.ovr = 2'd2; end
            8'h3E: begin e.seg = 1'b1; e.ovr = 2'd3; end
            8'hF2, 8'hF3, 8'hF0: ;
            default: begin e.is_opc = 1'b1; e.data = b; end
        endcase
        fifo_q.push_back(b);
        exp_q.push_back(e);
        drive_fifo();
    endtask

    // One clock: sample the pop request mid-cycle, then retire the popped
    // byte and match any produced event against the scoreboard.
    task automatic cycle();
        exp_t       e;
        logic [7:0] tmp;
        @(negedge clk);
        last_pop = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        if (last_pop && fifo_q.size() != 0) begin
            tmp = fifo_q.pop_front();
            drive_fifo();
        end
        if (bus.update) begin
            if (exp_q.size() == 0) begin
                check("spurious_update", 16'(bus.update), 16'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_update", 16'd0, 16'(e.is_opc));
                check("segment_override", 16'(bus.segment_override), 16'(e.seg));
                check("override_in", 16'(bus.override_in), 16'(e.ovr));
            end
        end
        if (bus.opcode_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
                check("spurious_opcode", 16'(bus.opcode_valid), 16'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_opcode", 16'd1, 16'(e.is_opc));
                check("opcode", 16'(bus.opcode), 16'(e.data));
            end
        end
        if (bus.opcode_valid)
            check("update_while_valid", 16'(bus.update), 16'd0);
        prev_ov = bus.opcode_valid;
    endtask

    task automatic wait_opcode(input int budget);
        for (int i = 0; i < budget && !bus.opcode_valid; i++) cycle();
        check("opcode_wait", 16'(bus.opcode_valid), 16'd1);
    endtask

    task automatic pulse_ack();
        bus.opcode_ack = 1'b1;
        cycle();
        bus.opcode_ack = 1'b0;
    endtask

    task automatic pulse_next();
        bus.next_instruction = 1'b1;
        cycle();
        bus.next_instruction = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
    endtask

    task automatic finish_instr();
        pulse_ack();
        check("ack_clears_valid", 16'(bus.opcode_valid), 16'd0);
        pulse_next();
        check("next_clears_count", 16'(bus.prefix_count), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                = 1'b1;
        bus.flush            = 1'b0;
        bus.next_instruction = 1'b0;
        bus.opcode_ack       = 1'b0;
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        check("rst_opcode_valid", 16'(bus.opcode_valid), 16'd0);
        check("rst_opcode", 16'(bus.opcode), 16'h00);
        check("rst_update", 16'(bus.update), 16'd0);
        check("rst_rep", 16'(bus.rep_prefix), 16'd0);
        check("rst_count", 16'(bus.prefix_count), 16'd0);
        reset = 1'b0;

        // 26,36,8B: two segment overrides then an opcode
        load(8'h26); load(8'h36); load(8'h8B);
        cycle();
        check("t1_count1", 16'(bus.prefix_count), 16'd1);
        cycle();
        check("t1_count2", 16'(bus.prefix_count), 16'd2);
        cycle();
        check("t1_valid", 16'(bus.opcode_valid), 16'd1);
        check("t1_no_update", 16'(bus.update), 16'd0);
        pulse_ack();
        check("t1_exec_valid", 16'(bus.opcode_valid), 16'd0);
        check("t1_exec_opcode", 16'(bus.opcode), 16'h8B);
        check("t1_exec_count", 16'(bus.prefix_count), 16'd2);
        pulse_next();
        check("t1_count_clear", 16'(bus.prefix_count), 16'd0);

        // F3,F2,A4: last REP wins, opcode held without ack
        load(8'hF3); load(8'hF2); load(8'hA4);
        cycle();
        check("t2_rep_f3", 16'(bus.rep_prefix), 16'b11);
        cycle();
        check("t2_rep_f2", 16'(bus.rep_prefix), 16'b10);
        wait_opcode(4);
        load(8'h90);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2_hold_no_pop", 16'(last_pop), 16'd0);
            check("t2_hold_opcode", 16'(bus.opcode), 16'hA4);
            check("t2_hold_valid", 16'(bus.opcode_valid), 16'd1);
        end
        pulse_ack();
        check("t2_exec_rep", 16'(bus.rep_prefix), 16'b10);
        pulse_next();
        check("t2_rep_clear", 16'(bus.rep_prefix), 16'd0);
        wait_opcode(4);
        finish_instr();

        // F0,90: LOCK tracked through EXEC, cleared by next_instruction
        load(8'hF0); load(8'h90);
        cycle();
        check("t3_lock", 16'(bus.lock), 16'd1);
        wait_opcode(4);
        pulse_ack();
        check("t3_exec_lock", 16'(bus.lock), 16'd1);
        pulse_next();
        check("t3_lock_clear", 16'(bus.lock), 16'd0);
        check("t3_count_clear", 16'(bus.prefix_count), 16'd0);
        load(8'hC3);
        cycle();
        check("t3_pop_resumes", 16'(last_pop), 16'd1);
        wait_opcode(4);
        finish_instr();

        // flush with a 2E at the head: no pop, no pulse, byte survives
        bus.flush = 1'b1;
        load(8'h2E);
        cycle();
        bus.flush = 1'b0;
        check("t4_flush_no_pop", 16'(last_pop), 16'd0);
        check("t4_flush_update", 16'(bus.update), 16'd0);
        check("t4_flush_seg", 16'(bus.segment_override), 16'd0);
        check("t4_flush_valid", 16'(bus.opcode_valid), 16'd0);
        check("t4_flush_count", 16'(bus.prefix_count), 16'd0);
        check("t4_fifo_kept", 16'(fifo_q.size()), 16'd1);
        cycle();
        check("t4_count_after", 16'(bus.prefix_count), 16'd1);
        load(8'hF3);
        cycle();
        check("t4_rep_set", 16'(bus.rep_prefix), 16'b11);
        pulse_flush();
        check("t4_flush_rep", 16'(bus.rep_prefix), 16'd0);
        check("t4_flush_count2", 16'(bus.prefix_count), 16'd0);
        check("t4_flush_update2", 16'(bus.update), 16'd0);
        load(8'h8B);
        wait_opcode(4);
        bus.flush = 1'b1;
        bus.opcode_ack = 1'b1;
        cycle();
        bus.flush = 1'b0;
        bus.opcode_ack = 1'b0;
        check("t4_hold_flush_valid", 16'(bus.opcode_valid), 16'd0);
        load(8'h90);
        cycle();
        check("t4_back_in_scan", 16'(last_pop), 16'd1);
        wait_opcode(4);
        finish_instr();

        // saturation at MAX_P=2: third prefix sets overflow
        load(8'h26); load(8'h26); load(8'h26); load(8'h90);
        cycle();
        check("t5_count1", 16'(bus.prefix_count), 16'd1);
        cycle();
        check("t5_count2", 16'(bus.prefix_count), 16'd2);
        check("t5_no_ovf", 16'(bus.prefix_overflow), 16'd0);
        cycle();
        check("t5_count_sat", 16'(bus.prefix_count), 16'd2);
        check("t5_ovf", 16'(bus.prefix_overflow), 16'd1);
        wait_opcode(4);
        pulse_ack();
        check("t5_ovf_sticky", 16'(bus.prefix_overflow), 16'd1);
        pulse_next();
        check("t5_ovf_clear", 16'(bus.prefix_overflow), 16'd0);

        // asynchronous reset while holding an opcode
        load(8'h8B);
        wait_opcode(4);
        #3 reset = 1'b1;
        #1;
        check("t6_async_valid", 16'(bus.opcode_valid), 16'd0);
        check("t6_async_opcode", 16'(bus.opcode), 16'h00);
        exp_q.delete();
        fifo_q.delete();
        drive_fifo();
        prev_ov = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        load(8'h26); load(8'h90);
        cycle();
        check("t6_fresh_count", 16'(bus.prefix_count), 16'd1);
        wait_opcode(4);
        finish_instr();

        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
